// File: rtl/processor_pkg.sv
// rtl/processor_pkg.sv - shared pipeline constants, status codes and multdiv sequencer state type
package processor_pkg;

    // Opcode field value for R-type ALU instructions.
    localparam logic [4:0] OP_ALU = 5'd0;

    // ALU op field values that route to the shared multdiv unit.
    localparam logic [4:0] ALUOP_MUL = 5'd6;
    localparam logic [4:0] ALUOP_DIV = 5'd7;

    // Status register written on a multdiv exception or timeout.
    localparam logic [4:0] RSTATUS = 5'd30;

    // Status codes written to RSTATUS.
    localparam logic [31:0] ST_MUL_OVF    = 32'd4;
    localparam logic [31:0] ST_DIV_ZERO   = 32'd5;
    localparam logic [31:0] ST_MD_TIMEOUT = 32'd6;

    typedef enum logic [1:0] {
        MD_IDLE  = 2'd0,
        MD_BUSY  = 2'd1,
        MD_DONE  = 2'd2,
        MD_DRAIN = 2'd3
    } md_state_t;

endpackage

// File: rtl/md_decode.sv
// rtl/md_decode.sv - combinational decode of mul/div from the DX instruction
//   ir     in  32 : instruction in DX
//   is_md  out  1 : instruction is mul or div
//   is_div out  1 : instruction is div
//   rd     out  5 : destination register field
module md_decode
    import processor_pkg::*;
(
    input  logic [31:0] ir,
    output logic        is_md,
    output logic        is_div,
    output logic [4:0]  rd
);

    logic        alu_op;
    logic [4:0]  aluop;
    logic        unused_bits;

    assign alu_op = (ir[31:27] == OP_ALU);
    assign aluop  = ir[6:2];
    assign is_md  = alu_op && ((aluop == ALUOP_MUL) || (aluop == ALUOP_DIV));
    assign is_div = (aluop == ALUOP_DIV);
    assign rd     = ir[26:22];

    // Source, shamt and low bits play no part in sequencing.
    assign unused_bits = ^{ir[21:7], ir[1:0]};

endmodule

// File: rtl/multdiv_ctrl.sv
// rtl/multdiv_ctrl.sv - sequencer that issues mul/div to the shared multdiv unit and injects the writeback into XM
//   Optional feature: MULTDIV_TIMEOUT_EN (bounded wait of TIMEOUT cycles for md_rdy)
//   clock, reset(async, active-low)
//   dx_ir, dx_opA, dx_opB, flush        : DX stage instruction, operands, squash
//   md_opA, md_opB, md_ctrl_mult/div    : operands and start pulses to multdiv unit
//   md_result, md_exception, md_rdy     : multdiv unit outputs
//   stall                               : hold PC/FD/DX (combinational)
//   res_valid, res_rd, res_data         : result write injected into XM
module multdiv_ctrl
    import processor_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] dx_ir,
    input  logic [31:0] dx_opA,
    input  logic [31:0] dx_opB,
    input  logic        flush,
    output logic [31:0] md_opA,
    output logic [31:0] md_opB,
    output logic        md_ctrl_mult,
    output logic        md_ctrl_div,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_rdy,
    output logic        stall,
    output logic        res_valid,
    output logic [4:0]  res_rd,
    output logic [31:0] res_data
);

    md_state_t   state, state_nxt;
    logic        is_md, is_div;
    logic [4:0]  rd_dec;
    logic        op_div_q;
    logic [4:0]  rd_q;
    logic        pulse;
    logic        issue;
    logic        rdy_ok;
    logic        busy_to;
    logic        drain_to;

    md_decode u_decode (
        .ir     (dx_ir),
        .is_md  (is_md),
        .is_div (is_div),
        .rd     (rd_dec)
    );

    // The start pulse marks the first BUSY cycle; md_rdy seen then belongs
    // to the previous operation and must not be taken as this result.
    assign pulse  = md_ctrl_mult | md_ctrl_div;
    assign issue  = (state == MD_IDLE) && is_md && !flush;
    assign rdy_ok = md_rdy && !pulse;

`ifdef MULTDIV_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT) + 1;
    logic [CW-1:0] cnt;

    assign busy_to  = (state == MD_BUSY) && !pulse && !md_rdy && (cnt == CW'(TIMEOUT - 1));
    assign drain_to = (state == MD_DRAIN) && (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (issue || ((state == MD_BUSY) && (state_nxt == MD_DRAIN))) begin
            cnt <= '0;
        end else if ((state == MD_BUSY) || (state == MD_DRAIN)) begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    logic timeout_unused;
    assign timeout_unused = (TIMEOUT > 0);
    assign busy_to  = 1'b0;
    assign drain_to = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        case (state)
            MD_IDLE: begin
                if (issue) begin
                    stall     = 1'b1;
                    state_nxt = MD_BUSY;
                end
            end
            MD_BUSY: begin
                stall = 1'b1;
                // A flush coinciding with ready means the unit is already
                // idle, so there is nothing left to drain.
                if (flush)                  state_nxt = rdy_ok ? MD_IDLE : MD_DRAIN;
                else if (rdy_ok || busy_to) state_nxt = MD_DONE;
            end
            MD_DONE: begin
                state_nxt = MD_IDLE;
            end
            MD_DRAIN: begin
                stall = is_md;
                if (md_rdy || drain_to) state_nxt = MD_IDLE;
            end
            default: state_nxt = MD_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= MD_IDLE;
            op_div_q     <= 1'b0;
            rd_q         <= '0;
            md_opA       <= '0;
            md_opB       <= '0;
            md_ctrl_mult <= 1'b0;
            md_ctrl_div  <= 1'b0;
            res_valid    <= 1'b0;
            res_rd       <= '0;
            res_data     <= '0;
        end else begin
            state        <= state_nxt;
            md_ctrl_mult <= 1'b0;
            md_ctrl_div  <= 1'b0;
            res_valid    <= 1'b0;
            if (issue) begin
                op_div_q     <= is_div;
                rd_q         <= rd_dec;
                md_opA       <= dx_opA;
                md_opB       <= dx_opB;
                md_ctrl_mult <= !is_div;
                md_ctrl_div  <= is_div;
            end
            if ((state == MD_BUSY) && (state_nxt == MD_DONE)) begin
                res_valid <= 1'b1;
                if (!rdy_ok) begin
                    res_rd   <= RSTATUS;
                    res_data <= ST_MD_TIMEOUT;
                end else if (md_exception) begin
                    res_rd   <= RSTATUS;
                    res_data <= op_div_q ? ST_DIV_ZERO : ST_MUL_OVF;
                end else begin
                    res_rd   <= rd_q;
                    res_data <= (rd_q == 5'd0) ? 32'd0 : md_result;
                end
            end
        end
    end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// tb/tb_multdiv_ctrl.sv - directed self-checking bench for multdiv_ctrl with a result scoreboard
module tb_multdiv_ctrl;

`ifdef MULTDIV_TIMEOUT_EN
    localparam int TB_TO = 8;
`else
    localparam int TB_TO = 64;
`endif

    logic        clock;
    logic        reset;
    logic [31:0] dx_ir, dx_opA, dx_opB;
    logic        flush;
    logic [31:0] md_opA, md_opB;
    logic        md_ctrl_mult, md_ctrl_div;
    logic [31:0] md_result;
    logic        md_exception;
    logic        md_rdy;
    logic        stall;
    logic        res_valid;
    logic [4:0]  res_rd;
    logic [31:0] res_data;

    int n_checks = 0;
    int n_pass   = 0;

    logic [36:0] sb_q[$];

    // Multdiv unit model controls.
    int          unit_lat  = 4;
    logic        unit_exc  = 1'b0;
    logic [31:0] unit_res  = 32'd0;
    logic        hold_rdy  = 1'b0;
    int          pulses    = 0;
    int          countdown = 0;

    multdiv_ctrl #(.TIMEOUT(TB_TO)) dut (
        .clock        (clock),
        .reset        (reset),
        .dx_ir        (dx_ir),
        .dx_opA       (dx_opA),
        .dx_opB       (dx_opB),
        .flush        (flush),
        .md_opA       (md_opA),
        .md_opB       (md_opB),
        .md_ctrl_mult (md_ctrl_mult),
        .md_ctrl_div  (md_ctrl_div),
        .md_result    (md_result),
        .md_exception (md_exception),
        .md_rdy       (md_rdy),
        .stall        (stall),
        .res_valid    (res_valid),
        .res_rd       (res_rd),
        .res_data     (res_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] mk_ir(input logic div, input logic [4:0] rd);
        mk_ir = {5'd0, rd, 5'd1, 5'd2, 5'd0, (div ? 5'd7 : 5'd6), 2'b00};
    endfunction

    // Multdiv unit: md_rdy one cycle, unit_lat cycles after the start pulse
    // (unit_lat of 0 means it never answers).
    initial begin
        md_rdy       = 1'b0;
        md_result    = 32'd0;
        md_exception = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            md_rdy = 1'b0;
            if (md_ctrl_mult || md_ctrl_div) begin
                pulses++;
                countdown = unit_lat;
                if (hold_rdy) begin
                    md_rdy       = 1'b1;
                    md_result    = 32'h0000_0BAD;
                    md_exception = 1'b0;
                    hold_rdy     = 1'b0;
                end
            end else if (countdown > 0) begin
                countdown--;
                if (countdown == 0) begin
                    md_rdy       = 1'b1;
                    md_result    = unit_res;
                    md_exception = unit_exc;
                end
            end
        end
    end

    // Result monitor: every res_valid must match the oldest expected write.
    initial begin
        logic [36:0] exp;
        forever begin
            @(negedge clock);
            if (reset && res_valid) begin
                if (sb_q.size() == 0) begin
                    chk("res_valid_unexpected", {31'd0, res_valid}, 32'd0);
                end else begin
                    exp = sb_q.pop_front();
                    chk("res_rd", {27'd0, res_rd}, {27'd0, exp[36:32]});
                    chk("res_data", res_data, exp[31:0]);
                end
            end
        end
    end

    // Count stalled cycles from the issue cycle until stall drops (DONE),
    // then put a nop into DX as the pipeline advances.
    task automatic wait_done(output int n);
        n = 0;
        for (int i = 0; i < 300; i++) begin
            #1;
            if (!stall) break;
            n++;
            @(negedge clock);
        end
        chk("stall_released", {31'd0, stall}, 32'd0);
        dx_ir = 32'd0;
    endtask

    task automatic run_op(input logic div, input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input logic exc, input logic [31:0] res,
                          input logic [4:0] exp_rd, input logic [31:0] exp_data, output int n);
        unit_lat = lat;
        unit_exc = exc;
        unit_res = res;
        sb_q.push_back({exp_rd, exp_data});
        @(negedge clock);
        dx_ir  = mk_ir(div, rd);
        dx_opA = a;
        dx_opB = b;
        wait_done(n);
    endtask

    initial begin
        int n;
        int p0;
        reset  = 1'b0;
        dx_ir  = 32'd0;
        dx_opA = 32'd0;
        dx_opB = 32'd0;
        flush  = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_ctrl", {30'd0, md_ctrl_mult, md_ctrl_div}, 32'd0);
        chk("rst_opA", md_opA, 32'd0);
        chk("rst_opB", md_opB, 32'd0);
        chk("rst_res", {26'd0, res_valid, res_rd}, 32'd0);
        chk("rst_data", res_data, 32'd0);
        reset = 1'b1;
        @(negedge clock);

        // mul $r3 = 6*7, md_rdy 33 cycles after the pulse.
        p0 = pulses;
        run_op(1'b0, 5'd3, 32'd6, 32'd7, 33, 1'b0, 32'd42, 5'd3, 32'd42, n);
        chk("mul_stall_cycles", n, 35);
        chk("mul_pulses", pulses - p0, 1);
        chk("mul_opA", md_opA, 32'd6);
        chk("mul_opB", md_opB, 32'd7);

        // div by zero, then mul overflow, back to back.
        run_op(1'b1, 5'd5, 32'd9, 32'd0, 4, 1'b1, 32'd0, 5'd30, 32'd5, n);
        chk("div0_stall_cycles", n, 6);
        run_op(1'b0, 5'd4, 32'hFFFF_FFFF, 32'd2, 2, 1'b1, 32'd0, 5'd30, 32'd4, n);
        chk("mulovf_stall_cycles", n, 4);

        // Write to $r0 is forced to zero.
        run_op(1'b0, 5'd0, 32'd3, 32'd33, 3, 1'b0, 32'd99, 5'd0, 32'd0, n);
        chk("r0_stall_cycles", n, 5);

        // Flush 5 cycles into BUSY; md_rdy 20 cycles later is discarded.
        unit_lat = 25;
        unit_res = 32'h1111;
        unit_exc = 1'b0;
        p0 = pulses;
        @(negedge clock);
        dx_ir  = mk_ir(1'b0, 5'd6);
        dx_opA = 32'd2;
        dx_opB = 32'd2;
        repeat (6) @(negedge clock);
        flush = 1'b1;
        @(negedge clock);
        flush  = 1'b0;
        dx_ir  = mk_ir(1'b0, 5'd8);
        dx_opA = 32'd3;
        dx_opB = 32'd5;
        #1;
        chk("drain_stall_new_md", {31'd0, stall}, 32'd1);
        unit_lat = 3;
        unit_res = 32'd15;
        sb_q.push_back({5'd8, 32'd15});
        wait_done(n);
        chk("flush_pulses", pulses - p0, 2);
        chk("after_drain_opA", md_opA, 32'd3);

        // md_rdy held during the start pulse is stale.
        hold_rdy = 1'b1;
        run_op(1'b1, 5'd9, 32'd154, 32'd2, 5, 1'b0, 32'd77, 5'd9, 32'd77, n);
        chk("stale_rdy_stall_cycles", n, 7);

`ifdef MULTDIV_TIMEOUT_EN
        // Unit never answers: timeout status 8 cycles after the pulse.
        run_op(1'b0, 5'd11, 32'd1, 32'd1, 0, 1'b0, 32'd0, 5'd30, 32'd6, n);
        chk("timeout_stall_cycles", n, 9);
`endif

        // Asynchronous reset in the middle of BUSY.
        unit_lat = 30;
        @(negedge clock);
        dx_ir  = mk_ir(1'b0, 5'd12);
        dx_opA = 32'd5;
        dx_opB = 32'd5;
        repeat (3) @(negedge clock);
        #2;
        reset = 1'b0;
        dx_ir = 32'd0;
        #1;
        chk("arst_stall", {31'd0, stall}, 32'd0);
        chk("arst_opA", md_opA, 32'd0);
        chk("arst_opB", md_opB, 32'd0);
        chk("arst_res", {25'd0, res_valid, res_rd, md_ctrl_mult}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        repeat (40) @(negedge clock);

        chk("scoreboard_empty", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
